// File: rtl/com_event_scheduler.sv
// Per-channel level-change detector with pending/overflow tracking and a
// round-robin arbiter that hands events to the host one at a time via valid/ready.
module com_event_scheduler #(
  parameter int NUM_SIGNALS = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic [NUM_SIGNALS-1:0] com_in,
  input  logic [NUM_SIGNALS-1:0] mask,
  input  logic                   evt_ready,
  input  logic                   ovf_clr,
  output logic                   evt_valid,
  output logic [IDX_WIDTH-1:0]   evt_idx,
  output logic                   evt_level,
  output logic                   pending_any,
  output logic [NUM_SIGNALS-1:0] ovf
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LAST_RST = IDX_WIDTH'(NUM_SIGNALS - 1);

  logic [0:0]             state_q, state_d;
  logic [NUM_SIGNALS-1:0] prev_q, prev_d;
  logic [NUM_SIGNALS-1:0] pending_q, pending_d;
  logic [NUM_SIGNALS-1:0] lvl_q, lvl_d;
  logic [NUM_SIGNALS-1:0] ovf_q, ovf_d;
  logic [IDX_WIDTH-1:0]   evt_idx_q, evt_idx_d;
  logic                   evt_level_q, evt_level_d;
  logic [IDX_WIDTH-1:0]   last_q, last_d;
  logic                   pending_any_q, pending_any_d;

  logic [NUM_SIGNALS-1:0] chg;
  logic [NUM_SIGNALS-1:0] grant_vec;
  logic [IDX_WIDTH-1:0]   sel;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   found;
  logic                   grant;

  assign chg = (com_in ^ prev_q) & mask;

  // Walk downward so the candidate closest to last+1 is the one left in sel.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = NUM_SIGNALS - 1; k >= 0; k--) begin
      cand = IDX_WIDTH'((int'(last_q) + 1 + k) % NUM_SIGNALS);
      if (pending_q[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant     = (state_q == IDLE) && found;
    grant_vec = '0;
    if (grant) grant_vec[sel] = 1'b1;

    prev_d        = com_in;
    pending_d     = (pending_q & ~grant_vec) | chg;
    lvl_d         = (lvl_q & ~chg) | (com_in & chg);
    ovf_d         = (ovf_clr ? '0 : ovf_q) | (chg & pending_q & ~grant_vec);
    pending_any_d = |pending_d;

    state_d     = state_q;
    evt_idx_d   = evt_idx_q;
    evt_level_d = evt_level_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          evt_idx_d   = sel;
          evt_level_d = lvl_q[sel];
          state_d     = PRESENT;
        end
      end
      default: begin
        if (evt_ready) begin
          last_d  = evt_idx_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q       <= IDLE;
      prev_q        <= '1;
      pending_q     <= '0;
      lvl_q         <= '1;
      ovf_q         <= '0;
      evt_idx_q     <= '0;
      evt_level_q   <= 1'b1;
      last_q        <= LAST_RST;
      pending_any_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      lvl_q         <= lvl_d;
      ovf_q         <= ovf_d;
      evt_idx_q     <= evt_idx_d;
      evt_level_q   <= evt_level_d;
      last_q        <= last_d;
      pending_any_q <= pending_any_d;
    end
  end

  assign evt_valid   = (state_q == PRESENT);
  assign evt_idx     = evt_idx_q;
  assign evt_level   = evt_level_q;
  assign pending_any = pending_any_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_com_event_scheduler.sv
// Directed bench for com_event_scheduler: expected events are queued by the
// stimulus and popped by a monitor at each accepted handshake.
module tb_com_event_scheduler;

  logic        clk = 1'b0;
  logic        aclr;
  logic [15:0] com_in;
  logic [15:0] mask;
  logic        evt_ready;
  logic        ovf_clr;
  logic        evt_valid;
  logic [3:0]  evt_idx;
  logic        evt_level;
  logic        pending_any;
  logic [15:0] ovf;

  typedef struct packed {
    logic [3:0] idx;
    logic       lvl;
  } evt_t;

  evt_t exp_q[$];
  int   acc_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  com_event_scheduler #(.NUM_SIGNALS(16), .IDX_WIDTH(4)) dut (
    .clk(clk), .aclr(aclr), .com_in(com_in), .mask(mask),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_idx(evt_idx), .evt_level(evt_level), .pending_any(pending_any),
    .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted handshake must match the head of the queue.
  always @(negedge clk) begin
    if (!aclr && evt_valid && evt_ready) begin
      evt_t e;
      acc_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got idx=%0d level=%0d, none expected", evt_idx, evt_level);
      end else begin
        e = exp_q.pop_front();
        if (evt_idx !== e.idx || evt_level !== e.lvl) begin
          bad++;
          $display("FAIL event: got idx=%0d level=%0d, want idx=%0d level=%0d",
                   evt_idx, evt_level, e.idx, e.lvl);
        end else begin
          $display("event ok: idx=%0d level=%0d cycle=%0d", evt_idx, evt_level, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic expect_evt(input int idx, input logic lvl);
    evt_t e;
    e.idx = 4'(idx);
    e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    step();
    aclr = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (exp_q.size() == 0 && !evt_valid) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: %0d events still queued after %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (evt_valid) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout: evt_valid not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    aclr      = 1'b1;
    com_in    = 16'hFFFF;
    mask      = 16'hFFFF;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    #1;
    check("reset_valid", 16'(evt_valid), 16'd0);
    do_reset();

    // Quiescent input after reset
    check("reset_idx", 16'(evt_idx), 16'd0);
    check("reset_level", 16'(evt_level), 16'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", 16'(evt_valid), 16'd0);
      check("idle_pending_any", 16'(pending_any), 16'd0);
      check("idle_ovf", ovf, 16'h0000);
    end

    // Single channel, latency and one-cycle pulse
    com_in[5] = 1'b0;
    expect_evt(5, 1'b0);
    step();
    check("lat_n1_valid", 16'(evt_valid), 16'd0);
    check("lat_n1_pending_any", 16'(pending_any), 16'd1);
    step();
    check("lat_n2_valid", 16'(evt_valid), 16'd1);
    check("lat_n2_idx", 16'(evt_idx), 16'd5);
    check("lat_n2_pending_any", 16'(pending_any), 16'd0);
    step();
    check("pulse_end_valid", 16'(evt_valid), 16'd0);
    com_in[5] = 1'b1;
    expect_evt(5, 1'b1);
    wait_drain("ch5_rise", 20);

    // Round-robin order from the reset pointer, then after last = 14
    do_reset();
    acc_cyc.delete();
    com_in = 16'hFFFF & ~16'h4204;
    expect_evt(2, 1'b0);
    expect_evt(9, 1'b0);
    expect_evt(14, 1'b0);
    wait_drain("rr3", 30);
    check("rr3_count", 16'(acc_cyc.size()), 16'd3);
    if (acc_cyc.size() == 3) begin
      check("rr3_gap0", 16'(acc_cyc[1] - acc_cyc[0]), 16'd2);
      check("rr3_gap1", 16'(acc_cyc[2] - acc_cyc[1]), 16'd2);
    end
    com_in[1]  = 1'b0;
    com_in[14] = 1'b1;
    expect_evt(1, 1'b0);
    expect_evt(14, 1'b1);
    wait_drain("rr2", 30);

    // Backpressure hold with overflow on channel 7
    com_in = 16'hFFFF;
    do_reset();
    evt_ready = 1'b0;
    com_in[3] = 1'b0;
    expect_evt(3, 1'b0);
    wait_valid("hold_start", 10);
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_valid", 16'(evt_valid), 16'd1);
      check("hold_idx", 16'(evt_idx), 16'd3);
      check("hold_level", 16'(evt_level), 16'd0);
      if (k == 2) com_in[7] = 1'b0;
      if (k == 5) begin
        com_in[7] = 1'b1;
        expect_evt(7, 1'b1);
      end
    end
    check("hold_ovf", ovf, 16'h0080);
    check("hold_pending_any", 16'(pending_any), 16'd1);
    evt_ready = 1'b1;
    wait_drain("hold", 20);
    check("ovf_sticky", ovf, 16'h0080);

    // Masked channel produces nothing, unmasking creates no stale event
    mask[4] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      com_in[4] = ~com_in[4];
      step();
      check("masked_pending_any", 16'(pending_any), 16'd0);
    end
    com_in[4] = 1'b0;
    step();
    mask[4] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("unmask_valid", 16'(evt_valid), 16'd0);
      check("unmask_pending_any", 16'(pending_any), 16'd0);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 16'h0000);

    // Asynchronous reset while presenting, with another channel pending
    evt_ready = 1'b0;
    com_in[6] = 1'b0;
    com_in[8] = 1'b0;
    wait_valid("aclr_pre", 10);
    step();
    check("aclr_pre_pending_any", 16'(pending_any), 16'd1);
    aclr   = 1'b1;
    com_in = 16'hFFFF;
    #1;
    check("aclr_async_valid", 16'(evt_valid), 16'd0);
    step();
    aclr = 1'b0;
    evt_ready = 1'b1;
    step();
    check("aclr_post_pending_any", 16'(pending_any), 16'd0);
    check("aclr_post_ovf", ovf, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      step();
      check("aclr_quiet_valid", 16'(evt_valid), 16'd0);
    end

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
